// File: rtl/twos_complement_serial_if.sv
// Request/result bundle for the bit-serial two's-complement unit.
// Master drives start/mode/din; slave returns busy/done/dout/ovf.
interface twos_complement_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             ovf;

  modport master (
    output start, mode, din,
    input  busy, done, dout, ovf
  );

  modport slave (
    input  start, mode, din,
    output busy, done, dout, ovf
  );
endinterface

// File: rtl/twos_complement_serial.sv
// Bit-serial PASS/ONES/TWOS/ABS converter, LSB first, one bit per clock.
// Define TWOS_COMPLEMENT_SERIAL_SAT_EN to clamp overflowing results to the most-positive value.
module twos_complement_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  twos_complement_serial_if.slave bus
);
  localparam int unsigned  CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [1:0]   M_ONES = 2'b01;
  localparam logic [1:0]   M_TWOS = 2'b10;
  localparam logic [1:0]   M_ABS  = 2'b11;
`ifdef TWOS_COMPLEMENT_SERIAL_SAT_EN
  localparam logic [WIDTH-1:0] SAT_VAL = {1'b0, {(WIDTH - 1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       mode_q;
  logic             sign_q;
  logic             seen_q;
  logic             zeros_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] dout_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic             in_bit_c;
  logic             neg_c;
  logic             out_bit_c;
  logic             ovf_c;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] final_d;

  // Operand bits leave at the bottom while result bits enter at the top,
  // so after WIDTH steps the register holds the complete result.
  always_comb begin
    in_bit_c  = sh_q[0];
    neg_c     = (mode_q == M_TWOS) || ((mode_q == M_ABS) && sign_q);
    out_bit_c = in_bit_c;
    if (mode_q == M_ONES) begin
      out_bit_c = ~in_bit_c;
    end else if (neg_c) begin
      out_bit_c = in_bit_c ^ seen_q;
    end
    sh_d  = {out_bit_c, sh_q[WIDTH-1:1]};
    // Only meaningful on the MSB step: sign set with every lower bit clear.
    ovf_c = mode_q[1] && in_bit_c && zeros_q;
`ifdef TWOS_COMPLEMENT_SERIAL_SAT_EN
    final_d = ovf_c ? SAT_VAL : sh_d;
`else
    final_d = sh_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      zeros_q <= 1'b0;
      sh_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= SHIFT;
            sh_q    <= bus.din;
            mode_q  <= bus.mode;
            sign_q  <= bus.din[WIDTH-1];
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            zeros_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          sh_q    <= sh_d;
          seen_q  <= seen_q | in_bit_c;
          zeros_q <= zeros_q & ~in_bit_c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dout_q  <= final_d;
            ovf_q   <= ovf_c;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_twos_complement_serial.sv
// Bench for twos_complement_serial: directed corner cases plus random conversions
// checked against an arithmetic reference model.
module tb_twos_complement_serial;
  localparam int unsigned W = 8;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W - 1){1'b1}}};
  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_ONES = 2'b01;
  localparam logic [1:0] M_TWOS = 2'b10;
  localparam logic [1:0] M_ABS  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] exp_dout = '0;
  logic         exp_ovf  = 1'b0;

  twos_complement_serial_if #(.WIDTH(W)) bus ();

  twos_complement_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns {ovf, dout} computed with plain arithmetic.
  function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic         o;
    case (m)
      M_PASS:  r = d;
      M_ONES:  r = ~d;
      M_TWOS:  r = -d;
      default: r = ($signed(d) < 0) ? -d : d;
    endcase
    o = m[1] && (d == MIN_NEG);
`ifdef TWOS_COMPLEMENT_SERIAL_SAT_EN
    if (o) r = MAX_POS;
`endif
    return {o, r};
  endfunction

  task automatic run_conv(input logic [1:0] m, input logic [W-1:0] d, input bit hold);
    logic [W:0] r;
    int lat;
    int nbusy;
    r = model(m, d);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.din   = d;
    @(negedge clk);
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < int'(W) + 4) begin
      if (bus.busy) nbusy++;
      check("stable_dout", 64'(bus.dout), 64'(exp_dout));
      check("stable_ovf", 64'(bus.ovf), 64'(exp_ovf));
      if (hold) begin
        bus.start = 1'b1;
        bus.mode  = M_TWOS;
        bus.din   = W'(1);
      end else begin
        bus.start = 1'($urandom);
        bus.mode  = 2'($urandom);
        bus.din   = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check("done", 64'(bus.done), 64'(1));
    check("latency", 64'(lat), 64'(W + 1));
    check("busy_cycles", 64'(nbusy), 64'(W));
    check("busy_in_done", 64'(bus.busy), 64'(0));
    check("dout", 64'(bus.dout), 64'(r[W-1:0]));
    check("ovf", 64'(bus.ovf), 64'(r[W]));
    exp_dout = r[W-1:0];
    exp_ovf  = r[W];
    if (!hold) bus.start = 1'($urandom);
    @(negedge clk);
    check("done_pulse_end", 64'(bus.done), 64'(0));
    check("idle_busy", 64'(bus.busy), 64'(0));
    check("hold_dout", 64'(bus.dout), 64'(exp_dout));
    if (hold) begin
      @(negedge clk);
      check("b2b_accept", 64'(bus.busy), 64'(1));
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < int'(W) + 4) begin
        @(negedge clk);
        lat++;
      end
      r = model(M_TWOS, W'(1));
      check("b2b_done", 64'(bus.done), 64'(1));
      check("b2b_dout", 64'(bus.dout), 64'(r[W-1:0]));
      check("b2b_ovf", 64'(bus.ovf), 64'(r[W]));
      exp_dout = r[W-1:0];
      exp_ovf  = r[W];
      @(negedge clk);
    end else begin
      bus.start = 1'b0;
      @(negedge clk);
      check("no_stray_accept", 64'(bus.busy), 64'(0));
    end
  endtask

  initial begin
    logic [1:0]   m;
    logic [W-1:0] d;
    int           sel;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = '0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_dout", 64'(bus.dout), 64'(0));
    check("rst_ovf", 64'(bus.ovf), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_conv(M_TWOS, 8'h05, 1'b0);
    run_conv(M_TWOS, 8'h80, 1'b0);
    run_conv(M_ABS,  8'hF6, 1'b0);
    run_conv(M_ABS,  8'h0A, 1'b0);
    run_conv(M_ONES, 8'h3C, 1'b0);
    run_conv(M_PASS, 8'h5A, 1'b0);
    run_conv(M_TWOS, 8'h00, 1'b0);
    run_conv(M_ABS,  8'h80, 1'b0);
    run_conv(M_TWOS, 8'h05, 1'b1);

    // Reset lands on the fourth shift edge of an in-flight conversion.
    bus.start = 1'b1;
    bus.mode  = M_TWOS;
    bus.din   = 8'h37;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_dout", 64'(bus.dout), 64'(0));
    check("abort_ovf", 64'(bus.ovf), 64'(0));
    exp_dout = '0;
    exp_ovf  = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'(0));
    end
    run_conv(M_TWOS, 8'h05, 1'b0);

    for (int i = 0; i < 150; i++) begin
      m   = 2'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      d = MIN_NEG;
      else if (sel == 1) d = '0;
      else               d = W'($urandom);
      run_conv(m, d, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/twos_complement_serial.md
TWOS_COMPLEMENT_SERIAL -- requirements
Module: twos_complement_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one conversion.
REQ-005 SHALL have port mode  input  2  operation: 00 PASS, 01 ONES (bitwise invert), 10 TWOS (negate), 11 ABS (absolute value).
REQ-006 SHALL have port din  input  WIDTH  operand, two's-complement signed.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; dout/ovf valid.
REQ-009 SHALL have port dout  output  WIDTH  result, held until next done.
REQ-010 SHALL have port ovf  output  1  result not representable (TWOS/ABS of most-negative value), held with dout.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start=1; SHIFT->DONE after WIDTH bit steps; DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL sample start, mode and din only in IDLE; on the accepting edge E0 it latches din and mode, clears the bit counter and sets busy=1.
REQ-013 SHALL ignore start while busy=1 or done=1; latched operand and mode unaffected by input changes mid-conversion.
REQ-014 SHALL process exactly one bit per edge, LSB first, on edges E1..E(WIDTH), using a counter of $clog2(WIDTH)+1 bits.
REQ-015 SHALL compute TWOS bit-serially: out_bit = in_bit XOR seen_one, then seen_one |= in_bit, seen_one cleared at E0.
REQ-016 SHALL compute ONES as out_bit = NOT in_bit, PASS as out_bit = in_bit.
REQ-017 SHALL compute ABS as TWOS when latched din[WIDTH-1]=1, else PASS.
REQ-018 SHALL update dout and ovf at edge E(WIDTH) and drive done=1, busy=0 for exactly the following cycle (latency WIDTH edges from acceptance).
REQ-019 SHALL set ovf=1 only for mode TWOS or ABS with din = 1 followed by WIDTH-1 zeros; ovf=0 otherwise, including din=0.
REQ-020 SHALL produce dout = din for TWOS/ABS of the most-negative value (natural wrap) unless REQ-026 applies.
REQ-021 SHALL produce TWOS of 0 as 0 with ovf=0.
REQ-022 SHALL accept a new start in the IDLE cycle immediately after DONE (back-to-back throughput one result per WIDTH+2 cycles).
REQ-023 SHALL keep dout/ovf stable outside the DONE-producing edge, never exposing partial results.

Reset
REQ-024 SHALL on rst=1 at a clock edge force state IDLE, busy=0, done=0, dout=0, ovf=0, counter=0, seen_one=0; rst has priority over start.
REQ-025 SHALL abort any conversion in progress on reset with no done pulse generated.

Configuration
REQ-026 SHALL, when macro TWOS_COMPLEMENT_SERIAL_SAT_EN is defined, saturate overflowing results to the most-positive value (0 followed by WIDTH-1 ones) with ovf=1; without the macro the wrapped result of REQ-020 is output, ovf still reported.

Verification
REQ-027 SHALL cover (WIDTH=8) TWOS din=0x05 -> after 8 edges done=1 for one cycle, dout=0xFB, ovf=0, busy high 8 cycles.
REQ-028 SHALL cover TWOS din=0x80 -> dout=0x80, ovf=1 without macro; dout=0x7F, ovf=1 with TWOS_COMPLEMENT_SERIAL_SAT_EN.
REQ-029 SHALL cover ABS din=0xF6 -> dout=0x0A; ABS din=0x0A -> dout=0x0A; ONES din=0x3C -> dout=0xC3; PASS din=0x5A -> dout=0x5A.
REQ-030 SHALL cover start=1 with din=0x01 held every cycle during conversion of 0x05 -> single result 0xFB, next start accepted only in the IDLE after DONE.
REQ-031 SHALL cover rst=1 at shift edge 4 of a conversion -> no done pulse, dout=0, busy=0, next start completes normally.
